// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU sizing defaults for ROM, fetch and decode
package cpu_pkg;

    localparam int IMEM_DATA_WIDTH = 32;
    localparam int IMEM_ADDR_WIDTH = 12;
    localparam int IMEM_RESET_PC   = 0;

    typedef logic [IMEM_ADDR_WIDTH-1:0] word_addr_t;
    typedef logic [IMEM_DATA_WIDTH-1:0] instr_word_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory, decode and redirect signals of the fetch stage
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = IMEM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = IMEM_ADDR_WIDTH
);
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_data;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     instr_valid;
    logic                     instr_ready;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid,
        input  imem_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid,
        output imem_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry hold buffer for a fetched instruction and its pc
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = IMEM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = IMEM_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_i,
    input  logic                     clear_i,
    input  logic                     flush_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o
);
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

    // flush beats load beats clear
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch from a registered ROM with stall hold and redirect
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = IMEM_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = IMEM_ADDR_WIDTH,
    parameter int RESET_PC      = IMEM_RESET_PC
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     inflight_q, inflight_d;
    logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic                     hold_valid;
    logic [DATA_WIDTH-1:0]    hold_instr;
    logic [ADDRESS_WIDTH-1:0] hold_pc;

    logic                     instr_valid_w;
    logic                     issue;
    logic                     hold_load;
    logic                     hold_clear;

    always_comb begin
        instr_valid_w = !bus.redirect_valid && (hold_valid || inflight_q);
        issue         = !bus.redirect_valid && (!instr_valid_w || bus.instr_ready);
        // a stalled ROM word moves into the hold buffer so the ROM can be re-read freely
        hold_load     = inflight_q && !hold_valid && !bus.instr_ready && !bus.redirect_valid;
        hold_clear    = hold_valid && bus.instr_ready && !bus.redirect_valid;

        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + ADDRESS_WIDTH'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= ADDRESS_WIDTH'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= ADDRESS_WIDTH'(RESET_PC);
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_buf #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .flush_i (bus.redirect_valid),
        .data_i  (bus.imem_data),
        .pc_i    (inflight_pc_q),
        .valid_o (hold_valid),
        .data_o  (hold_instr),
        .pc_o    (hold_pc)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.instr       = hold_valid ? hold_instr : bus.imem_data;
    assign bus.instr_pc    = hold_valid ? hold_pc : inflight_pc_q;
    assign bus.instr_valid = instr_valid_w;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(inflight_q && hold_valid));
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return 32'h1000_0000 + {20'd0, a};
    endfunction

    always @(posedge clk) bus.imem_data <= rom_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: accepted instructions form a consecutive pc stream from the last reset/redirect
    logic [11:0] exp_pc = 12'd0;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0, p_rstn = 1'b0;
    logic        pp_valid = 1'b0, pp_ready = 1'b0, pp_redir = 1'b0, pp_rstn = 1'b0;
    logic [31:0] p_instr = '0;
    logic [11:0] p_pc = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.redirect_valid || p_redir || !p_rstn) begin
                chk("m_valid_flushed", 32'(bus.instr_valid), 32'd0);
            end else if (pp_redir || !pp_rstn) begin
                chk("m_valid_restart", 32'(bus.instr_valid), 32'd1);
            end else if (p_valid && !p_ready) begin
                chk("m_valid_stalled", 32'(bus.instr_valid), 32'd1);
                chk("m_stall_pc", 32'(bus.instr_pc), 32'(p_pc));
                chk("m_stall_instr", bus.instr, p_instr);
            end else if (!p_valid || !(pp_valid && !pp_ready)) begin
                chk("m_valid_stream", 32'(bus.instr_valid), 32'd1);
            end
            if (bus.instr_valid) begin
                chk("m_pc_order", 32'(bus.instr_pc), 32'(exp_pc));
                chk("m_instr_data", bus.instr, rom_word(bus.instr_pc));
            end
        end
        if (!reset_n)                              exp_pc = 12'd0;
        else if (bus.redirect_valid)               exp_pc = bus.redirect_pc;
        else if (bus.instr_valid && bus.instr_ready) exp_pc = exp_pc + 12'd1;
        pp_valid = p_valid; pp_ready = p_ready; pp_redir = p_redir; pp_rstn = p_rstn;
        p_valid  = bus.instr_valid && reset_n;
        p_ready  = bus.instr_ready;
        p_redir  = bus.redirect_valid;
        p_rstn   = reset_n;
        p_instr  = bus.instr;
        p_pc     = bus.instr_pc;
    end

    initial begin
        int acc0, acc1, got, bub;
        logic [47:0] ready_pat;
        reset_n = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_valid", 32'(bus.instr_valid), 32'd0);
        chk("reset_addr", 32'(bus.imem_addr), 32'd0);

        step(); reset_n = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(bus.instr_valid), 32'd0);
        chk("release_addr", 32'(bus.imem_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("boot_valid", 32'(bus.instr_valid), 32'd1);
            chk("boot_pc", 32'(bus.instr_pc), 32'(i));
            chk("boot_instr", bus.instr, 32'h1000_0000 + 32'(i));
        end

        step(); step(); bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_pc", 32'(bus.instr_pc), 32'h5);
            chk("stall_instr", bus.instr, 32'h1000_0005);
            if (k < 2) step();
        end
        step(); bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("release_accept_pc", 32'(bus.instr_pc), 32'h5);
        acc0 = -1; acc1 = -1; got = 0; bub = 0;
        for (int k = 0; k < 4 && got < 2; k++) begin
            step();
            @(negedge clk);
            if (bus.instr_valid) begin
                if (got == 0) acc0 = int'(bus.instr_pc);
                else          acc1 = int'(bus.instr_pc);
                got++;
            end else begin
                bub++;
            end
        end
        chk("after_release_pc0", 32'(acc0), 32'h6);
        chk("after_release_pc1", 32'(acc1), 32'h7);
        chk("release_bubbles_le1", 32'(bub <= 1), 32'd1);

        step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h200;
        @(negedge clk); chk("redir_valid_c0", 32'(bus.instr_valid), 32'd0);
        step(); bus.redirect_valid = 1'b0;
        @(negedge clk); chk("redir_valid_c1", 32'(bus.instr_valid), 32'd0);
        step();
        @(negedge clk); chk("redir_pc0", 32'(bus.instr_pc), 32'h200);
        chk("redir_instr0", bus.instr, 32'h1000_0200);
        step();
        @(negedge clk); chk("redir_pc1", 32'(bus.instr_pc), 32'h201);

        step(); bus.instr_ready = 1'b0;
        @(negedge clk); chk("hold_pc_a", 32'(bus.instr_pc), 32'h202);
        step(); step();
        @(negedge clk); chk("hold_pc_b", 32'(bus.instr_pc), 32'h202);
        step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h040; bus.instr_ready = 1'b1;
        @(negedge clk); chk("hredir_valid_c0", 32'(bus.instr_valid), 32'd0);
        step(); bus.redirect_valid = 1'b0;
        @(negedge clk); chk("hredir_valid_c1", 32'(bus.instr_valid), 32'd0);
        step();
        @(negedge clk); chk("hredir_valid", 32'(bus.instr_valid), 32'd1);
        chk("hredir_pc", 32'(bus.instr_pc), 32'h040);
        chk("hredir_instr", bus.instr, 32'h1000_0040);

        step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 12'hFFE;
        step(); bus.redirect_valid = 1'b0;
        step(); @(negedge clk); chk("wrap_pc0", 32'(bus.instr_pc), 32'hFFE);
        step(); @(negedge clk); chk("wrap_pc1", 32'(bus.instr_pc), 32'hFFF);
        step(); @(negedge clk); chk("wrap_pc2", 32'(bus.instr_pc), 32'h000);
        chk("wrap_instr2", bus.instr, 32'h1000_0000);

        step(); bus.instr_ready = 1'b0;
        step(); step();
        step(); reset_n = 1'b0; bus.instr_ready = 1'b1;
        step(); reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
        step();
        @(negedge clk);
        chk("midrst_restart_valid", 32'(bus.instr_valid), 32'd1);
        chk("midrst_restart_pc", 32'(bus.instr_pc), 32'd0);

        ready_pat = 48'hF37E_DBFF_19BE;
        for (int i = 0; i < 48; i++) begin
            step();
            bus.instr_ready    = ready_pat[i];
            bus.redirect_valid = (i == 20) || (i == 33);
            bus.redirect_pc    = (i == 20) ? 12'h123 : 12'hFFF;
        end
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, instruction word width.
REQ-002 SHALL have parameter: ADDRESS_WIDTH, 12, instruction-memory word-address width.
REQ-003 SHALL have parameter: RESET_PC, 0, word address fetched first after reset.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: imem_addr  output  ADDRESS_WIDTH  word address to instruction ROM (ROM registers read; data valid next cycle).
REQ-007 SHALL have port: imem_data  input  DATA_WIDTH  ROM read data for the address presented the previous cycle.
REQ-008 SHALL have port: instr  output  DATA_WIDTH  fetched instruction to decode.
REQ-009 SHALL have port: instr_pc  output  ADDRESS_WIDTH  address of instr.
REQ-010 SHALL have port: instr_valid  output  1  instr/instr_pc valid.
REQ-011 SHALL have port: instr_ready  input  1  decode accepts instr this cycle.
REQ-012 SHALL have port: redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port: redirect_pc  input  ADDRESS_WIDTH  redirect target word address.

Function
REQ-014 SHALL hold state: pc register, inflight flag + inflight_pc, one-entry hold buffer (hold_valid, hold_instr, hold_pc).
REQ-015 SHALL drive imem_addr = pc register directly (no combinational path from inputs).
REQ-016 SHALL define issue = !redirect_valid && (!instr_valid || instr_ready); on issue: pc <= pc+1, inflight <= 1, inflight_pc <= pc.
REQ-017 SHALL, when not issuing and no redirect, hold pc and set inflight <= 0 (ROM re-read of same address is ignored).
REQ-018 SHALL increment pc modulo 2^ADDRESS_WIDTH (max address wraps to 0).
REQ-019 SHALL present, when hold_valid: instr=hold_instr, instr_pc=hold_pc, instr_valid=1; else instr=imem_data, instr_pc=inflight_pc, instr_valid=inflight; instr_valid forced 0 while redirect_valid.
REQ-020 SHALL capture imem_data/inflight_pc into hold when inflight && !hold_valid && !instr_ready && !redirect_valid.
REQ-021 SHALL clear hold_valid when hold_valid && instr_ready && !redirect_valid.
REQ-022 SHALL never have inflight and hold_valid both 1.
REQ-023 SHALL, on redirect_valid (priority over all else): pc <= redirect_pc, inflight <= 0, hold_valid <= 0; first redirected instruction valid 2 cycles after redirect cycle.
REQ-024 SHALL keep instr/instr_pc stable while instr_valid && !instr_ready.
REQ-025 SHALL sustain one instruction per cycle while instr_ready stays 1; each stall release costs at most one bubble.

Reset
REQ-026 SHALL, while reset_n=0 at clk edge: pc <= RESET_PC, inflight <= 0, hold_valid <= 0; instr_valid=0, imem_addr=RESET_PC the cycle after.
REQ-027 SHALL issue RESET_PC in first cycle with reset_n=1; instr_valid=1 with instr_pc=RESET_PC the following cycle.
REQ-028 SHALL discard any in-flight or held instruction on reset asserted mid-stream; no stale instr_valid after reset.

Structure
REQ-029 SHALL take DATA_WIDTH, ADDRESS_WIDTH, RESET_PC defaults from shared package cpu_pkg (shared with ROM and decode).
REQ-030 SHALL implement hold buffer as sub-module fetch_skid_buf (one entry, valid/data/pc, load/clear/flush controls).

Verification
REQ-031 SHALL test reset: ROM[i]=0x1000_0000+i, ready=1, release reset -> instr_pc 0,1,2,3 on consecutive cycles, instr=0x1000_0000..0x1000_0003.
REQ-032 SHALL test stall: drop instr_ready 3 cycles while instr_pc=5 -> instr_pc=5/instr stable all 3 cycles, then 5,(bubble),6,7 after release; no skip/duplicate.
REQ-033 SHALL test redirect: redirect_valid one cycle with redirect_pc=0x200 while streaming -> instr_valid=0 that cycle and next, then instr_pc=0x200, 0x201.
REQ-034 SHALL test redirect during stall: hold_valid=1, redirect_pc=0x040 -> held instruction dropped, next valid instr_pc=0x040.
REQ-035 SHALL test wrap: redirect_pc=0xFFE, ready=1 -> instr_pc 0xFFE,0xFFF,0x000.
REQ-036 SHALL test mid-stream reset: reset_n=0 one cycle during stall -> instr_valid=0, restart at RESET_PC; assertion REQ-022 holds throughout.
